// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: peripheral bus strobes plus irq handshake lines for irq_ctrl.
// Bus data travels on a separate tri-state net beside this interface.
interface irq_ctrl_if #(
    parameter int CPU_WIDTH = 16,
    parameter int N_IRQ     = 4,
    parameter int VEC_W     = 2
) ();
    logic                 EN;
    logic [CPU_WIDTH-1:0] addr;
    logic                 ctrl;
    logic [N_IRQ-1:0]     irq_src;
    logic                 irq_ack;
    logic                 irq_cpu;
    logic [VEC_W-1:0]     irq_vec;

    modport master (
        output EN, addr, ctrl, irq_src, irq_ack,
        input  irq_cpu, irq_vec
    );

    modport slave (
        input  EN, addr, ctrl, irq_src, irq_ack,
        output irq_cpu, irq_vec
    );
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-latching interrupt controller with req/ack/EOI sequencing.
// Define IRQ_RR_EN for round-robin arbitration; default is fixed priority (index 0 first).
`ifndef IO_CTRL_WRITE
`define IO_CTRL_WRITE 1'b1
`endif
`ifndef IO_CTRL_READ
`define IO_CTRL_READ 1'b0
`endif

module irq_ctrl #(
    parameter int CPU_WIDTH = 16,
    parameter int N_IRQ     = 4,
    parameter int VEC_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    irq_ctrl_if.slave            bus,
    inout  wire  [CPU_WIDTH-1:0] data
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_SERV = 2'd2;

    logic [N_IRQ-1:0]     r_pend;
    logic [N_IRQ-1:0]     r_mask;
    logic [N_IRQ-1:0]     r_src_d;
    logic [1:0]           r_state;
    logic                 r_cpu;
    logic [VEC_W-1:0]     r_vec;

    logic                 w_wr;
    logic                 w_rd;
    logic                 w_ack;
    logic                 w_eoi;
    logic [N_IRQ-1:0]     w_edge;
    logic [N_IRQ-1:0]     w_req;
    logic [N_IRQ-1:0]     w_clr;
    logic [N_IRQ-1:0]     w_vec_hot;
    logic [VEC_W-1:0]     w_win;
    logic [CPU_WIDTH-1:0] w_rdata;
    logic                 w_unused;

    assign w_wr      = bus.EN && (bus.ctrl == `IO_CTRL_WRITE);
    assign w_rd      = bus.EN && (bus.ctrl == `IO_CTRL_READ);
    assign w_ack     = bus.irq_ack && (r_state == S_REQ);
    assign w_eoi     = w_wr && (bus.addr[1:0] == 2'd3) && (r_state == S_SERV);
    assign w_edge    = bus.irq_src & ~r_src_d;
    assign w_req     = r_pend & r_mask;
    assign w_vec_hot = N_IRQ'(1) << r_vec;
    assign w_unused  = ^{bus.addr, data};

    // Clears (W1C, ack) are applied first so a same-cycle edge still sets the bit.
    always_comb begin
        w_clr = '0;
        if (w_wr && (bus.addr[1:0] == 2'd0))
            w_clr = data[N_IRQ-1:0];
        if (w_ack)
            w_clr = w_clr | w_vec_hot;
    end

`ifdef IRQ_RR_EN
    logic [VEC_W-1:0] r_rr;

    // Descending scan so the candidate nearest rr_ptr (after wrap) is written last.
    always_comb begin : arb_rr
        int idx;
        w_win = '0;
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            idx = int'(r_rr) + k;
            if (idx >= N_IRQ)
                idx = idx - N_IRQ;
            if (w_req[idx])
                w_win = VEC_W'(idx);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_rr <= '0;
        else if (w_ack)
            r_rr <= (r_vec == VEC_W'(N_IRQ - 1)) ? '0 : r_vec + 1'b1;
    end
`else
    always_comb begin
        w_win = '0;
        for (int i = N_IRQ - 1; i >= 0; i--)
            if (w_req[i])
                w_win = VEC_W'(i);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend  <= '0;
            r_mask  <= '0;
            r_src_d <= '1;
            r_state <= S_IDLE;
            r_cpu   <= 1'b0;
            r_vec   <= '0;
        end else begin
            r_src_d <= bus.irq_src;
            r_pend  <= (r_pend & ~w_clr) | w_edge;
            if (w_wr && (bus.addr[1:0] == 2'd1))
                r_mask <= data[N_IRQ-1:0];
            case (r_state)
                S_IDLE: if (|w_req) begin
                    r_vec   <= w_win;
                    r_cpu   <= 1'b1;
                    r_state <= S_REQ;
                end
                S_REQ: if (bus.irq_ack) begin
                    r_cpu   <= 1'b0;
                    r_state <= S_SERV;
                end
                S_SERV: if (w_eoi)
                    r_state <= S_IDLE;
                default: begin
                    r_cpu   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_rdata = '0;
        case (bus.addr[1:0])
            2'd0:    w_rdata[N_IRQ-1:0] = r_pend;
            2'd1:    w_rdata[N_IRQ-1:0] = r_mask;
            2'd2:    w_rdata[VEC_W+1:0] = {r_state, r_vec};
            default: w_rdata = '0;
        endcase
    end

    assign data        = w_rd ? w_rdata : 'z;
    assign bus.irq_cpu = r_cpu;
    assign bus.irq_vec = r_vec;
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed protocol scenarios plus random traffic against a behavioural model.
module tb_irq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        oe  = 1'b0;
    logic [15:0] wd  = 16'd0;
    wire  [15:0] data;
    int          total = 0;
    int          bad   = 0;
    bit          run_chk = 1'b0;

    irq_ctrl_if bus ();

    assign data = oe ? wd : 16'bz;

    irq_ctrl dut (.clk(clk), .rst(rst), .bus(bus), .data(data));

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [3:0] m_pend, m_mask, m_prev, m_old_req;
    int         m_st, m_vec, m_rr;
    bit         m_cpu, m_wr;
    logic [1:0] m_a;

    function automatic int pick(input logic [3:0] req, input int rr);
        int k;
`ifdef IRQ_RR_EN
        for (k = 0; k < 4; k++)
            if (req[(rr + k) % 4]) return (rr + k) % 4;
`else
        for (k = 0; k < 4; k++)
            if (req[k]) return k;
`endif
        return 0;
    endfunction

    function automatic logic [15:0] mread(input logic [1:0] a);
        logic [1:0] s, v;
        s = m_st[1:0];
        v = m_vec[1:0];
        case (a)
            2'd0:    return {12'd0, m_pend};
            2'd1:    return {12'd0, m_mask};
            2'd2:    return {12'd0, s, v};
            default: return 16'd0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend = 0; m_mask = 0; m_prev = 4'hF;
            m_st = 0; m_cpu = 0; m_vec = 0; m_rr = 0;
        end else begin
            m_old_req = m_pend & m_mask;
            m_wr = bus.EN && bus.ctrl;
            m_a  = bus.addr[1:0];
            if (m_wr && m_a == 2'd0) m_pend = m_pend & ~wd[3:0];
            if (m_st == 1 && bus.irq_ack) m_pend[m_vec] = 1'b0;
            m_pend = m_pend | (bus.irq_src & ~m_prev);
            m_prev = bus.irq_src;
            if (m_wr && m_a == 2'd1) m_mask = wd[3:0];
            if (m_st == 0) begin
                if (m_old_req != 0) begin
                    m_vec = pick(m_old_req, m_rr); m_st = 1; m_cpu = 1;
                end
            end else if (m_st == 1) begin
                if (bus.irq_ack) begin
                    m_rr = (m_vec + 1) % 4; m_st = 2; m_cpu = 0;
                end
            end else if (m_wr && m_a == 2'd3) begin
                m_st = 0;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (!rst && run_chk) begin
            chk("cyc_cpu", 16'(bus.irq_cpu), 16'(m_cpu));
            chk("cyc_vec", 16'(bus.irq_vec), 16'(m_vec[1:0]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(input logic [1:0] a, input logic [15:0] v);
        @(negedge clk);
        bus.EN = 1'b1; bus.ctrl = 1'b1; bus.addr = {14'd0, a}; wd = v; oe = 1'b1;
        @(negedge clk);
        bus.EN = 1'b0; oe = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [1:0] a, input logic [15:0] exp);
        bus.EN = 1'b1; bus.ctrl = 1'b0; bus.addr = {14'd0, a}; oe = 1'b0;
        #1;
        chk(nm, data, exp);
        chk({nm, "_mdl"}, data, mread(a));
        #1;
        bus.EN = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] m);
        @(negedge clk); bus.irq_src = bus.irq_src | m;
        @(negedge clk); bus.irq_src = bus.irq_src & ~m;
    endtask

    task automatic ack();
        @(negedge clk); bus.irq_ack = 1'b1;
        @(negedge clk); bus.irq_ack = 1'b0;
    endtask

    task automatic wait_cpu(input string nm, input logic [1:0] exp_vec);
        int n = 0;
        while (!bus.irq_cpu && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_cpu"}, 16'(bus.irq_cpu), 16'd1);
        chk({nm, "_vec"}, 16'(bus.irq_vec), 16'(exp_vec));
    endtask

    initial begin
        bus.EN = 1'b0; bus.addr = '0; bus.ctrl = 1'b0;
        bus.irq_src = '0; bus.irq_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        run_chk = 1'b1;

        // reset state
        chk("rst_cpu", 16'(bus.irq_cpu), 16'd0);
        chk("rst_vec", 16'(bus.irq_vec), 16'd0);
        rd_chk("rst_pend", 2'd0, 16'h0);
        rd_chk("rst_mask", 2'd1, 16'h0);
        rd_chk("rst_stat", 2'd2, 16'h0);

        // basic request / ack / EOI with latency
        wr(2'd1, 16'h0002);
        rd_chk("t2_mask", 2'd1, 16'h2);
        pulse(4'b0010);
        chk("t2_lat1", 16'(bus.irq_cpu), 16'd0);
        rd_chk("t2_pend", 2'd0, 16'h2);
        @(negedge clk);
        chk("t2_lat2", 16'(bus.irq_cpu), 16'd1);
        chk("t2_vec", 16'(bus.irq_vec), 16'd1);
        rd_chk("t2_stat_req", 2'd2, 16'h5);
        ack();
        chk("t2_cpu_off", 16'(bus.irq_cpu), 16'd0);
        rd_chk("t2_pend_clr", 2'd0, 16'h0);
        rd_chk("t2_stat_serv", 2'd2, 16'h9);
        wr(2'd3, 16'h1234);
        rd_chk("t2_stat_idle", 2'd2, 16'h1);
        rd_chk("t2_eoi_rd", 2'd3, 16'h0);

        // masked source becomes visible when unmasked
        wr(2'd1, 16'h0000);
        pulse(4'b1000);
        rd_chk("t3_pend", 2'd0, 16'h8);
        chk("t3_cpu_masked", 16'(bus.irq_cpu), 16'd0);
        wr(2'd1, 16'hFFF8);
        rd_chk("t3_mask_hi", 2'd1, 16'h8);
        chk("t3_lat1", 16'(bus.irq_cpu), 16'd0);
        @(negedge clk);
        chk("t3_lat2", 16'(bus.irq_cpu), 16'd1);
        chk("t3_vec", 16'(bus.irq_vec), 16'd3);
        ack();
        wr(2'd3, 16'h0);

        // arbitration
        wr(2'd1, 16'h000F);
        pulse(4'b0101);
        wait_cpu("t4a", 2'd0);
        ack();
        pulse(4'b0001);
        wr(2'd3, 16'h0);
`ifdef IRQ_RR_EN
        wait_cpu("t4b", 2'd2);
`else
        wait_cpu("t4b", 2'd0);
`endif
        ack();
        wr(2'd3, 16'h0);
`ifdef IRQ_RR_EN
        wait_cpu("t4c", 2'd0);
`else
        wait_cpu("t4c", 2'd2);
`endif
        ack();
        wr(2'd3, 16'h0);

        // collisions: W1C vs edge, ack vs edge
        wr(2'd1, 16'h0000);
        @(negedge clk);
        bus.EN = 1'b1; bus.ctrl = 1'b1; bus.addr = 16'd0; wd = 16'h0002; oe = 1'b1;
        bus.irq_src[1] = 1'b1;
        @(negedge clk);
        bus.EN = 1'b0; oe = 1'b0; bus.irq_src[1] = 1'b0;
        rd_chk("t5_w1c_set", 2'd0, 16'h2);
        wr(2'd0, 16'h0002);
        rd_chk("t5_w1c_clr", 2'd0, 16'h0);
        wr(2'd1, 16'h0002);
        pulse(4'b0010);
        wait_cpu("t5", 2'd1);
        @(negedge clk);
        bus.irq_ack = 1'b1; bus.irq_src[1] = 1'b1;
        @(negedge clk);
        bus.irq_ack = 1'b0; bus.irq_src[1] = 1'b0;
        rd_chk("t5_ack_set", 2'd0, 16'h2);
        rd_chk("t5_stat", 2'd2, 16'h9);
        wr(2'd3, 16'h0);
        wait_cpu("t5b", 2'd1);
        ack();

        // protocol: stray ack in SERV, stray EOI in IDLE
        ack();
        rd_chk("t6_ack_serv", 2'd2, 16'h9);
        wr(2'd1, 16'h0000);
        wr(2'd3, 16'h0);
        rd_chk("t6_idle", 2'd2, 16'h1);
        wr(2'd3, 16'h0);
        rd_chk("t6_eoi_idle", 2'd2, 16'h1);

        // async reset in REQ, lines held high across release
        wr(2'd1, 16'h0004);
        pulse(4'b0100);
        wait_cpu("t1", 2'd2);
        #2 rst = 1'b1;
        bus.irq_src = 4'hF;
        #1;
        chk("t1_cpu", 16'(bus.irq_cpu), 16'd0);
        chk("t1_vec", 16'(bus.irq_vec), 16'd0);
        rd_chk("t1_pend", 2'd0, 16'h0);
        rd_chk("t1_mask", 2'd1, 16'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rd_chk("t6_held_pend", 2'd0, 16'h0);
        wr(2'd1, 16'h000F);
        @(negedge clk);
        chk("t6_held_cpu", 16'(bus.irq_cpu), 16'd0);
        bus.irq_src = 4'h0;

        // random traffic, model-checked every cycle and on every read
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.irq_src = 4'($urandom);
            bus.irq_ack = ($urandom_range(3) == 0);
            bus.EN = 1'b0; oe = 1'b0;
            case ($urandom_range(4))
                0: begin
                    bus.EN = 1'b1; bus.ctrl = 1'b1; oe = 1'b1;
                    bus.addr = 16'($urandom); wd = 16'($urandom);
                end
                1: begin
                    bus.EN = 1'b1; bus.ctrl = 1'b0;
                    bus.addr = 16'($urandom);
                    #1;
                    chk("rnd_rd", data, mread(bus.addr[1:0]));
                end
                default: ;
            endcase
        end
        @(negedge clk);
        bus.EN = 1'b0; oe = 1'b0; bus.irq_ack = 1'b0;
        @(negedge clk);
        run_chk = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
